// File: rtl/pillar_ctrl.sv
// Pillar scroller for the flappy-bird game: two looping pillars, LFSR-driven gap
// heights, bird-column scoring and the IDLE/RUN/DEAD game-state machine.
module pillar_ctrl #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned PILLAR_W = 52,
  parameter int unsigned STEP     = 2,
  parameter int unsigned Y_INIT   = 200,
  parameter int unsigned Y_MIN    = 80,
  parameter int unsigned BIRD_X   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  output logic [9:0] pillar_down_x0,
  output logic [9:0] pillar_down_x1,
  output logic [8:0] pillar_y0,
  output logic [8:0] pillar_y1,
  output logic       pillar_vld0,
  output logic       pillar_vld1,
  output logic [9:0] score,
  output logic       score_pulse,
  output logic [1:0] game_state
);

  localparam logic [9:0]  WRAP_X    = 10'(SCREEN_W + PILLAR_W - 1);
  localparam logic [9:0]  HALF_X    = 10'((SCREEN_W + PILLAR_W - 1) / 2);
  localparam logic [9:0]  STEP_X    = 10'(STEP);
  localparam logic [9:0]  BIRD_COL  = 10'(BIRD_X);
  localparam logic [8:0]  Y_RST     = 9'(Y_INIT);
  localparam logic [8:0]  Y_LO      = 9'(Y_MIN);
  localparam logic [9:0]  SCORE_MAX = 10'd999;
  localparam logic [15:0] SEED      = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic [15:0] lfsr;
  logic [8:0]  y_rand;
  logic [9:0]  x0_nx, x1_nx, score_nx;
  logic [8:0]  y0_nx, y1_nx;
  logic        vld0_nx, vld1_nx, pulse_nx;
  logic        cross0, cross1;
  logic [1:0]  hits;
  logic [10:0] sum;

  // Wrap test comes before the subtraction so x never underflows.
  function automatic logic [9:0] advance(input logic [9:0] x);
    return (x >= STEP_X) ? x - STEP_X : WRAP_X;
  endfunction

  assign y_rand = Y_LO + {1'b0, lfsr[7:0]};

  // Galois form of x^16+x^14+x^13+x^11+1; maximal length, so a nonzero seed never reaches zero.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (crash) state_nx = DEAD;
      DEAD:    if (start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    game_state = state;
  end

  always_comb begin
    x0_nx    = pillar_down_x0;
    x1_nx    = pillar_down_x1;
    y0_nx    = pillar_y0;
    y1_nx    = pillar_y1;
    vld0_nx  = pillar_vld0;
    vld1_nx  = pillar_vld1;
    score_nx = score;
    pulse_nx = 1'b0;
    cross0   = 1'b0;
    cross1   = 1'b0;
    hits     = '0;
    sum      = '0;
    unique case (state)
      IDLE: if (start) begin
        vld0_nx = 1'b1;
        y0_nx   = y_rand;
      end
      RUN: if (!crash && frame_tick) begin
        // Pillar 1 uses its pre-edge valid, so it holds at WRAP_X on the edge it is enabled.
        if (pillar_vld0) begin
          x0_nx  = advance(pillar_down_x0);
          cross0 = (pillar_down_x0 >= BIRD_COL) && (x0_nx < BIRD_COL);
          if (pillar_down_x0 < STEP_X) y0_nx = y_rand;
          if (x0_nx <= HALF_X) vld1_nx = 1'b1;
        end
        if (pillar_vld1) begin
          x1_nx  = advance(pillar_down_x1);
          cross1 = (pillar_down_x1 >= BIRD_COL) && (x1_nx < BIRD_COL);
          if (pillar_down_x1 < STEP_X) y1_nx = y_rand;
        end
        hits = {1'b0, cross0} + {1'b0, cross1};
        sum  = {1'b0, score} + {9'b0, hits};
        if (hits != 2'd0) begin
          pulse_nx = 1'b1;
          score_nx = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
        end
      end
      DEAD: if (start) begin
        x0_nx    = WRAP_X;
        x1_nx    = WRAP_X;
        y0_nx    = Y_RST;
        y1_nx    = Y_RST;
        vld0_nx  = 1'b0;
        vld1_nx  = 1'b0;
        score_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pillar_down_x0 <= WRAP_X;
      pillar_down_x1 <= WRAP_X;
      pillar_y0      <= Y_RST;
      pillar_y1      <= Y_RST;
      pillar_vld0    <= 1'b0;
      pillar_vld1    <= 1'b0;
      score          <= '0;
      score_pulse    <= 1'b0;
    end else begin
      pillar_down_x0 <= x0_nx;
      pillar_down_x1 <= x1_nx;
      pillar_y0      <= y0_nx;
      pillar_y1      <= y1_nx;
      pillar_vld0    <= vld0_nx;
      pillar_vld1    <= vld1_nx;
      score          <= score_nx;
      score_pulse    <= pulse_nx;
    end
  end

endmodule

// File: tb/tb_pillar_ctrl.sv
// Bench for pillar_ctrl: a default-parameter DUT and a small-screen DUT, both
// tracked cycle by cycle against a modular-arithmetic game model.
module tb_pillar_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0, frame_tick = 1'b0, start = 1'b0, crash = 1'b0;

  logic [9:0] x0_a, x1_a, sc_a, x0_b, x1_b, sc_b;
  logic [8:0] y0_a, y1_a, y0_b, y1_b;
  logic       v0_a, v1_a, sp_a, v0_b, v1_b, sp_b;
  logic [1:0] gs_a, gs_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pillar_ctrl dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .crash(crash),
    .pillar_down_x0(x0_a), .pillar_down_x1(x1_a), .pillar_y0(y0_a), .pillar_y1(y1_a),
    .pillar_vld0(v0_a), .pillar_vld1(v1_a), .score(sc_a), .score_pulse(sp_a),
    .game_state(gs_a)
  );

  pillar_ctrl #(
    .SCREEN_W(100), .PILLAR_W(20), .STEP(4), .Y_INIT(100), .Y_MIN(40), .BIRD_X(50)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .crash(crash),
    .pillar_down_x0(x0_b), .pillar_down_x1(x1_b), .pillar_y0(y0_b), .pillar_y1(y1_b),
    .pillar_vld0(v0_b), .pillar_vld1(v1_b), .score(sc_b), .score_pulse(sp_b),
    .game_state(gs_b)
  );

  typedef struct {
    int sw, pw, stp, yi, ymin, bx;
  } prm_t;

  typedef struct {
    int st, x0, x1, y0, y1, v0, v1, score, pulse;
    logic [15:0] lfsr;
  } mdl_t;

  prm_t pa = '{640, 52, 2, 200, 80, 200};
  prm_t pb = '{100, 20, 4, 100, 40, 50};
  mdl_t ma, mb;

  // Polynomial x^16+x^14+x^13+x^11+1, one step per clock.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic mdl_t init(input prm_t p, input mdl_t m);
    mdl_t n = m;
    n.st = 0; n.x0 = p.sw + p.pw - 1; n.x1 = p.sw + p.pw - 1;
    n.y0 = p.yi; n.y1 = p.yi; n.v0 = 0; n.v1 = 0; n.score = 0; n.pulse = 0;
    return n;
  endfunction

  // Positions live on a ring of SCREEN_W+PILLAR_W columns; moving left past 0 lands on the far end.
  function automatic mdl_t step(input mdl_t m, input prm_t p, input bit r, input bit tk,
                                input bit s, input bit c);
    mdl_t n = m;
    int lap = p.sw + p.pw;
    int hits = 0;
    n.lfsr  = lfsr_adv(m.lfsr);
    n.pulse = 0;
    if (r) begin
      n = init(p, n);
      n.lfsr = 16'hACE1;
      return n;
    end
    if (m.st == 0) begin
      if (s) begin n.st = 1; n.v0 = 1; n.y0 = p.ymin + int'(m.lfsr[7:0]); end
    end else if (m.st == 1) begin
      if (c) n.st = 2;
      else if (tk) begin
        if (m.v0 != 0) begin
          n.x0 = (m.x0 - p.stp + lap) % lap;
          if (n.x0 > m.x0) n.y0 = p.ymin + int'(m.lfsr[7:0]);
          else if (m.x0 >= p.bx && n.x0 < p.bx) hits++;
          if (n.x0 <= (lap - 1) / 2) n.v1 = 1;
        end
        if (m.v1 != 0) begin
          n.x1 = (m.x1 - p.stp + lap) % lap;
          if (n.x1 > m.x1) n.y1 = p.ymin + int'(m.lfsr[7:0]);
          else if (m.x1 >= p.bx && n.x1 < p.bx) hits++;
        end
        if (hits > 0) begin
          n.pulse = 1;
          n.score = (m.score + hits > 999) ? 999 : m.score + hits;
        end
      end
    end else if (s) begin
      n = init(p, n);
    end
    return n;
  endfunction

  function automatic logic [63:0] pack(input mdl_t m);
    return {11'b0, 2'(m.st), 10'(m.x0), 10'(m.x1), 9'(m.y0), 9'(m.y1),
            1'(m.v0), 1'(m.v1), 10'(m.score), 1'(m.pulse)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit tk, input bit s, input bit c, input bit r);
    frame_tick = tk; start = s; crash = c; rst = r;
    @(posedge clk);
    ma = step(ma, pa, r, tk, s, c);
    mb = step(mb, pb, r, tk, s, c);
    #1;
    chk("model_a", {11'b0, gs_a, x0_a, x1_a, y0_a, y1_a, v0_a, v1_a, sc_a, sp_a}, pack(ma));
    chk("model_b", {11'b0, gs_b, x0_b, x1_b, y0_b, y1_b, v0_b, v1_b, sc_b, sp_b}, pack(mb));
    frame_tick = 1'b0; start = 1'b0; crash = 1'b0; rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_state"}, gs_a, 2'b00);
    chk({tag, "_x0"}, x0_a, 10'd691);
    chk({tag, "_x1"}, x1_a, 10'd691);
    chk({tag, "_y0"}, y0_a, 9'd200);
    chk({tag, "_y1"}, y1_a, 9'd200);
    chk({tag, "_vld"}, {v0_a, v1_a}, 2'b00);
    chk({tag, "_score"}, sc_a, 10'd0);
    chk({tag, "_pulse"}, sp_a, 1'b0);
  endtask

  logic [15:0] pre;
  int k;

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_reset_a("reset");
    chk("reset_b_x0", x0_b, 10'd119);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("idle_tick_x0", x0_a, 10'd691);
    chk("idle_crash_state", gs_a, 2'b00);

    pre = ma.lfsr;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_state", gs_a, 2'b01);
    chk("start_vld0", v0_a, 1'b1);
    chk("start_y0", y0_a, 9'(80 + int'(pre[7:0])));

    ticks(10);
    chk("run10_x0", x0_a, 10'd671);
    chk("run10_x1", x1_a, 10'd691);
    chk("run10_vld1", v1_a, 1'b0);
    chk("run10_state", gs_a, 2'b01);

    ticks(162);
    chk("pre_half_x0", x0_a, 10'd347);
    chk("pre_half_vld1", v1_a, 1'b0);
    ticks(1);
    chk("half_x0", x0_a, 10'd345);
    chk("half_vld1", v1_a, 1'b1);
    chk("half_x1_hold", x1_a, 10'd691);
    ticks(1);
    chk("after_half_x0", x0_a, 10'd343);
    chk("after_half_x1", x1_a, 10'd689);

    k = 0;
    while (ma.x0 != 201 && k < 2000) begin ticks(1); k++; end
    chk("at_bird_x0", x0_a, 10'd201);
    ticks(1);
    chk("cross_x0", x0_a, 10'd199);
    chk("cross_pulse", sp_a, 1'b1);
    chk("cross_score", sc_a, 10'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_once", sp_a, 1'b0);
    chk("score_hold", sc_a, 10'd1);

    k = 0;
    while (ma.x0 != 1 && k < 2000) begin ticks(1); k++; end
    chk("at_one_x0", x0_a, 10'd1);
    pre = ma.lfsr;
    ticks(1);
    chk("wrap_x0", x0_a, 10'd691);
    chk("wrap_y0", y0_a, 9'(80 + int'(pre[7:0])));

    k = 0;
    while (ma.x0 != 201 && k < 2000) begin ticks(1); k++; end
    chk("crash_pre_x0", x0_a, 10'd201);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("crash_x0", x0_a, 10'd201);
    chk("crash_pulse", sp_a, 1'b0);
    chk("crash_state", gs_a, 2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dead_frozen_x0", x0_a, 10'd201);
    chk("dead_state", gs_a, 2'b10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_reset_a("restart");

    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_reset_a("rst_run");

    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 299) == 0), 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    k = 0;
    while (mb.score < 999 && k < 20000) begin
      ticks(1);
      chk("b_y_range", {(y0_b >= 9'd40 && y0_b <= 9'd295), (y1_b >= 9'd40 && y1_b <= 9'd295)}, 2'b11);
      chk("a_y0_range", (y0_a >= 9'd80 && y0_a <= 9'd335), 1'b1);
      k++;
    end
    chk("b_reach_999", sc_b, 10'd999);
    k = 0;
    do begin ticks(1); k++; end while (mb.pulse == 0 && k < 200);
    chk("sat_pulse", sp_b, 1'b1);
    chk("sat_score", sc_b, 10'd999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pillar_ctrl.md
PILLAR_CTRL -- requirements
Module: pillar_ctrl

Interface
REQ-001 Parameter SCREEN_W, 640, visible columns.
REQ-002 Parameter PILLAR_W, 52, pillar sprite width in pixels.
REQ-003 Parameter STEP, 2, pixels moved per frame_tick; (SCREEN_W+PILLAR_W) SHALL be a multiple of STEP.
REQ-004 Parameter Y_INIT, 200, pillar_y value loaded at reset or on a DEAD->IDLE transition.
REQ-005 Parameter Y_MIN, 80, lowest randomized pillar_y.
REQ-006 Parameter BIRD_X, 200, bird column used for scoring.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous reset, active-high.
REQ-009 frame_tick  in  1  one-cycle pulse, once per VGA frame.
REQ-010 start  in  1  one-cycle pulse from the key debouncer.
REQ-011 crash  in  1  level from the collision checker.
REQ-012 pillar_down_x0, pillar_down_x1  out  10 each  rightmost column of each pillar; the sprite spans x-51..x.
REQ-013 pillar_y0, pillar_y1  out  9 each  bottom row of each downward pillar; the gap starts at pillar_y+1.
REQ-014 pillar_vld0, pillar_vld1  out  1 each  the pillar is to be drawn.
REQ-015 score  out  10  binary pillar count.
REQ-016 score_pulse  out  1  one-cycle pulse on each score increment.
REQ-017 game_state  out  2  00 IDLE, 01 RUN, 10 DEAD.

Function
REQ-018 All outputs SHALL be registered and change only on clk edges.
REQ-019 FSM IDLE: positions held; start -> RUN; crash ignored.
REQ-020 FSM RUN: pillars move on frame_tick; crash=1 -> DEAD in the same edge, and no motion or scoring is applied on that edge, even if frame_tick=1.
REQ-021 FSM DEAD: all outputs frozen; start -> IDLE with the full re-initialisation of REQ-034, score included.
REQ-022 A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clk cycle in every state and SHALL never reach zero.
REQ-023 On IDLE->RUN: pillar_vld0 <= 1; pillar_y0 <= Y_MIN + lfsr[7:0].
REQ-024 In RUN on frame_tick: for each valid pillar, if x >= STEP then x <= x - STEP, else x <= WRAP_X = SCREEN_W+PILLAR_W-1 (691).
REQ-025 On wrap, that pillar's y SHALL load Y_MIN + lfsr[7:0], giving a range of 80..335; pillars 0 and 1 sample the LFSR value of that cycle identically if both wrap together.
REQ-026 pillar_vld1 SHALL be set, and latched, on the edge where pillar_down_x0 becomes <= WRAP_X/2 (345). Pillar 1 stays at 691 until then and moves from the next frame_tick, so the two pillars remain 346 px apart modulo 692.
REQ-027 Score: on a frame_tick move where a valid pillar goes from old x >= BIRD_X to new x < BIRD_X, score SHALL increment by 1 and score_pulse SHALL be 1 for exactly one cycle.
REQ-028 Score SHALL saturate at 999. score_pulse still fires at saturation.
REQ-029 Both pillars crossing on the same tick SHALL add 2; this cannot occur with the defaults.
REQ-030 Arithmetic SHALL use a 10-bit x; the wrap test precedes the subtraction, so x never underflows.
REQ-031 frame_tick outside RUN SHALL have no effect.
REQ-032 Latency: positions update on the clk edge that samples frame_tick; downstream sprite modules see the new values in the following cycle.

Reset
REQ-033 rst SHALL take priority over all inputs, including mid-RUN or mid-DEAD.
REQ-034 Reset values: game_state=IDLE; x0=x1=691; y0=y1=Y_INIT; vld0=vld1=0; score=0; score_pulse=0.
REQ-035 Reset values (LFSR): lfsr=16'hACE1.

Verification
REQ-036 Reset: assert rst for 2 cycles -> the REQ-034 values are all present on the next edge; frame_tick has no effect while in IDLE.
REQ-037 Start plus motion: start, then 10 frame_ticks -> x0=671, x1=691, vld1=0, state=01.
REQ-038 Second pillar: after 173 ticks, x0=345 and vld1=1 on the same edge; the next tick gives x0=343, x1=689.
REQ-039 Wrap: with x0=1, one tick -> x0=691 and y0=80+lfsr[7:0] sampled that cycle; y0 stays within 80..335 over 1000 wraps.
REQ-040 Score: x0=201 plus tick -> x0=199, score_pulse=1 for one cycle, score=1. With score=999, the next crossing keeps score=999.
REQ-041 Crash and restart: crash together with tick at x0=201 -> x0 stays 201, no pulse, state=10. start -> state=00 with the reset values. rst mid-RUN -> the REQ-034 values.
